cam_power_sequencer: RTL
========================

// Module: cam_power_sequencer
// PURPOSE
//  Drives the OV7670 PWDN and RESET pins through the datasheet power-up order.
//  Sits downstream of the clean reset produced from PLL lock and consumes it.
//  Releases PWDN, holds RESET low, releases RESET, then waits a settle time.
//  Then issues one start pulse to the SCCB configurator, waits for its done,
//  and raises ready to the capture path. Guarantees the camera is never
//  configured before it has power and a completed reset.
// PARAMETERS
//  PWDN_CYCLES    25000     pclk cycles RESET held low after PWDN release (1 ms @25 MHz)
//  SETTLE_CYCLES  25000     pclk cycles after RESET release before SCCB access
//  CFG_TIMEOUT    2500000   pclk cycles allowed for cfg_done before fault (100 ms)
//  CNT_W          22        timer width; must hold max(PWDN_CYCLES, SETTLE_CYCLES, CFG_TIMEOUT)
// PORTS
//  pclk         in   1      system pixel-domain clock; all logic on rising edge
//  reset_n      in   1      synchronous, active-low reset
//  enable       in   1      level; 1 = power camera up, 0 = power down
//  cfg_done     in   1      one-cycle pulse (or level) from SCCB configurator
//  cam_pwdn     out  1      to OV7670 PWDN pin; 1 = powered down
//  cam_reset_n  out  1      to OV7670 RESET pin; 0 = in reset
//  cfg_start    out  1      one-cycle pulse to SCCB configurator
//  ready        out  1      camera configured; capture may start
//  fault        out  1      configuration timed out
//  state_o      out  3      current state encoding, for debug/LEDs
// BEHAVIOUR
//  Reset (reset_n=0 at pclk edge): state=S_OFF, timer=0, cam_pwdn=1, cam_reset_n=0,
//    cfg_start=0, ready=0, fault=0. All outputs are registered.
//  States (encodings 0..5):
//    S_OFF    pwdn=1 rst_n=0. enable=1 -> S_PWRUP, timer cleared.
//    S_PWRUP  pwdn=0 rst_n=0. Timer counts up. At timer==PWDN_CYCLES-1 -> S_SETTLE, timer cleared.
//    S_SETTLE pwdn=0 rst_n=1. At timer==SETTLE_CYCLES-1 -> S_CFG, timer cleared.
//      On the same edge, cfg_start=1 for exactly one cycle.
//    S_CFG    pwdn=0 rst_n=1. cfg_done=1 -> S_READY.
//      Otherwise, at timer==CFG_TIMEOUT-1 -> S_FAULT.
//    S_READY  ready=1. Holds while enable=1.
//    S_FAULT  fault=1, pwdn=0, rst_n=1. Holds until enable=0.
//  enable=0 in any state -> S_OFF on the next edge. All outputs return to their reset values.
//    This covers an abort mid-countdown.
//  enable re-asserted after S_OFF restarts the full sequence; there is no shortcut.
//  Latency from enable rise to the cfg_start pulse is PWDN_CYCLES+SETTLE_CYCLES+1 cycles.
//  cfg_done outside S_CFG is ignored.
//  cfg_done on the same cycle as the timeout edge: done wins -> S_READY.
//  enable=0 together with cfg_done or timeout: enable wins -> S_OFF.
//  The timer saturates; it never wraps. Timer compares are unsigned at CNT_W bits.
//  ready and fault are never both 1.
//  cfg_start is never asserted while cam_reset_n=0.
// STRUCTURE
//  cam_pkg: state localparams S_OFF..S_FAULT, and default cycle constants at 25 MHz.
//  One sub-module, seq_timer: CNT_W counter with clear, enable and saturate.
//    It outputs count_o. Compares against the parameters stay in the FSM.
//  FSM: one registered state with a registered output decode.
// TESTING (bench uses PWDN_CYCLES=8, SETTLE_CYCLES=6, CFG_TIMEOUT=20)
//  1 Reset held, enable=1 -> outputs stay pwdn=1 rst_n=0 ready=0. Release reset ->
//    pwdn falls on edge 1, rst_n rises 8 cycles later, cfg_start pulses 6 cycles after that.
//  2 cfg_done pulsed 3 cycles after cfg_start -> ready=1 next edge, fault stays 0.
//  3 No cfg_done -> fault=1 exactly 20 cycles after cfg_start. enable=0 -> S_OFF with pwdn=1.
//  4 enable dropped at PWRUP timer=4 -> S_OFF next edge. Re-enable -> full 8+6 count, no residue.
//  5 cfg_done asserted on the timeout edge -> S_READY.
//    In a separate case, enable=0 with cfg_done on the same edge -> S_OFF.
//  6 reset_n pulsed low for 1 cycle while in S_READY -> all outputs at reset values next edge.
//    Sequence reruns from S_OFF.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and default timing for the OV7670 power-up sequencer.
// Cycle defaults assume a 25 MHz pixel clock.
package cam_pkg;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWRUP  = 3'd1,
        S_SETTLE = 3'd2,
        S_CFG    = 3'd3,
        S_READY  = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam int unsigned PWDN_CYCLES_DEF   = 25000;
    localparam int unsigned SETTLE_CYCLES_DEF = 25000;
    localparam int unsigned CFG_TIMEOUT_DEF   = 2500000;
    localparam int unsigned CNT_W_DEF         = 22;

endpackage

// File: rtl/seq_timer.sv
// Up-counter with synchronous clear and enable.
// Saturates at all-ones instead of wrapping.
module seq_timer #(
    parameter int unsigned CNT_W = 22
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count_o
);

    always_ff @(posedge pclk) begin
        if (!reset_n || clr) begin
            count_o <= '0;
        end else if (en && (count_o != '1)) begin
            count_o <= count_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cam_power_sequencer.sv
// Steps the OV7670 through PWDN release, reset pulse, settle and SCCB config.
// Every output is a register loaded from the decode of the next state.
module cam_power_sequencer
    import cam_pkg::*;
#(
    parameter int unsigned PWDN_CYCLES   = PWDN_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned CFG_TIMEOUT   = CFG_TIMEOUT_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       cfg_done,
    output logic       cam_pwdn,
    output logic       cam_reset_n,
    output logic       cfg_start,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PWDN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(CFG_TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count;
    logic             tmr_clr;
    logic             tmr_en;
    logic             pwdn_d;
    logic             rstn_d;
    logic             start_d;
    logic             ready_d;
    logic             fault_d;

    // Any state change restarts the timer so each phase counts from zero.
    assign tmr_clr = (state_d != state_q);
    assign tmr_en  = (state_q == S_PWRUP) || (state_q == S_SETTLE) ||
                     (state_q == S_CFG);

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .pclk    (pclk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        if (!enable) begin
            state_d = S_OFF;
        end else begin
            unique case (state_q)
                S_OFF: state_d = S_PWRUP;
                S_PWRUP: begin
                    if (count == PW_LAST) state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (count == SE_LAST) begin
                        state_d = S_CFG;
                        start_d = 1'b1;
                    end
                end
                // done takes priority over a coincident timeout
                S_CFG: begin
                    if (cfg_done) begin
                        state_d = S_READY;
                    end else if (count == TO_LAST) begin
                        state_d = S_FAULT;
                    end
                end
                S_READY: state_d = S_READY;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_OFF;
            endcase
        end
    end

    always_comb begin
        pwdn_d  = 1'b0;
        rstn_d  = 1'b1;
        ready_d = 1'b0;
        fault_d = 1'b0;
        unique case (1'b1)
            (state_d == S_OFF): begin
                pwdn_d = 1'b1;
                rstn_d = 1'b0;
            end
            (state_d == S_PWRUP): rstn_d  = 1'b0;
            (state_d == S_READY): ready_d = 1'b1;
            (state_d == S_FAULT): fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_q     <= S_OFF;
            cam_pwdn    <= 1'b1;
            cam_reset_n <= 1'b0;
            cfg_start   <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cam_pwdn    <= pwdn_d;
            cam_reset_n <= rstn_d;
            cfg_start   <= start_d;
            ready       <= ready_d;
            fault       <= fault_d;
        end
    end

    assign state_o = state_q;

endmodule
